commit_halt_ctrl: RTL and testbench
===================================

COMMIT_HALT_CTRL -- requirements
Module: commit_halt_ctrl

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, meaning datapath and GPR width.
REQ-002 The block SHALL have parameter DRAIN_MAX, default 16, meaning max drain cycles before forced dump.
REQ-003 The block SHALL have clock and reset ports: clk input 1, rising-edge clock; rst_n input 1, reset.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 The block SHALL have commit_valid input 1, one instruction retires this cycle.
REQ-006 The block SHALL have commit_pc input XLEN, PC of the retiring instruction.
REQ-007 The block SHALL have commit_is_break input 1, the retiring instruction is ebreak; qualified by commit_valid.
REQ-008 The block SHALL have pipe_empty input 1, no instruction in flight after fetch.
REQ-009 The block SHALL have stall_fetch output 1, freeze instruction fetch.
REQ-010 The block SHALL have gpr_raddr output 5, GPR read port address.
REQ-011 The block SHALL have gpr_rdata input XLEN, combinational read data for gpr_raddr in the same cycle.
REQ-012 The block SHALL have dump_valid output 1, dump_idx output 5 and dump_data output XLEN, the GPR snapshot stream to the simulation harness.
REQ-013 The block SHALL have dump_ready input 1, harness accepts the dump beat.
REQ-014 The block SHALL have halted output 1, halt_pc output XLEN and good_trap output 1, final status.
REQ-015 The block SHALL have instret output 64 and cycles output 64, retire and cycle counters.

Function
REQ-016 The block SHALL implement FSM states RUN, DRAIN, DUMP and HALTED.
REQ-017 RUN -> DRAIN: the block SHALL take this transition on commit_valid&commit_is_break, latching commit_pc into halt_pc.
REQ-018 In RUN, instret SHALL increment by 1 on every commit_valid, including the break commit.
REQ-019 Outside RUN, commit_valid SHALL be ignored: no count, no latch.
REQ-020 stall_fetch SHALL be 1 in DRAIN, DUMP and HALTED, and 0 in RUN (combinational from state).
REQ-021 In DRAIN, a 5-bit drain counter SHALL start at 0 on entry and increment each cycle.
REQ-022 DRAIN -> DUMP: the block SHALL take this transition when pipe_empty=1, or when the drain counter reaches DRAIN_MAX-1; the timeout path SHALL set a sticky timeout flag.
REQ-023 In DUMP, dump_valid SHALL be 1, gpr_raddr SHALL equal dump_idx, and dump_data SHALL equal gpr_rdata, except that dump_data SHALL be 0 when dump_idx=0.
REQ-024 dump_idx SHALL start at 0 on DUMP entry and advance by 1 only on dump_valid&dump_ready.
REQ-025 dump_data and dump_idx SHALL hold stable while dump_valid&!dump_ready.
REQ-026 The beat with dump_idx=10 (a0) SHALL latch its dump_data into an a0 register when accepted.
REQ-027 DUMP -> HALTED: the block SHALL take this transition on acceptance of the dump_idx=31 beat; exactly 32 beats SHALL be accepted per halt.
REQ-028 In HALTED, halted SHALL be 1, and good_trap SHALL be 1 iff latched a0==0 and the timeout flag is 0.
REQ-029 HALTED SHALL be sticky until reset.
REQ-030 cycles SHALL increment every cycle in RUN, DRAIN and DUMP, and freeze in HALTED.
REQ-031 Both counters SHALL wrap modulo 2^64 without flagging.
REQ-032 If pipe_empty=1 on the DRAIN entry cycle, the block SHALL go DRAIN -> DUMP after exactly 1 DRAIN cycle.
REQ-033 dump_valid SHALL be 0 and gpr_raddr SHALL be 0 in all states except DUMP.

Reset
REQ-034 On rst_n=0, the block SHALL asynchronously enter RUN and clear instret, cycles, halt_pc, the a0 register, the timeout flag, and the drain and dump counters.
REQ-035 During reset, outputs SHALL be: stall_fetch=0, dump_valid=0, dump_idx=0, dump_data=0, halted=0, good_trap=0.
REQ-036 Reset asserted in any state, including mid-DUMP, SHALL abort the operation; no partial status SHALL survive.

Verification
REQ-037 5 commits then break at pc=0x80000014, pipe_empty=1, dump_ready=1, x10=0 -> 32 beats idx 0..31 on consecutive cycles, halted=1, halt_pc=0x80000014, good_trap=1, instret=6.
REQ-038 Break with x10=1 -> halted=1, good_trap=0.
REQ-039 dump_ready toggling 1,0,0,1,... -> idx advances only on ready, data stable while stalled, 32 beats total, no skipped or duplicate index.
REQ-040 pipe_empty held 0 after break -> DUMP entered after 16 DRAIN cycles; good_trap=0 even with x10=0.
REQ-041 x0 read port driven 0xDEAD -> beat idx 0 carries 0.
REQ-042 rst_n pulsed low at dump_idx=7 -> same-cycle return to RUN, halted=0, instret=0, cycles=0; a subsequent break performs a full 32-beat dump.

Source files
------------

// File: rtl/commit_halt_ctrl.sv
// Commit-side halt controller: on a retired ebreak it freezes fetch, drains the pipe,
// streams a 32-entry GPR snapshot to the harness and reports the final trap status.
module commit_halt_ctrl #(
    parameter int XLEN      = 64,
    parameter int DRAIN_MAX = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            commit_valid,
    input  logic [XLEN-1:0] commit_pc,
    input  logic            commit_is_break,
    input  logic            pipe_empty,
    output logic            stall_fetch,
    output logic [4:0]      gpr_raddr,
    input  logic [XLEN-1:0] gpr_rdata,
    output logic            dump_valid,
    output logic [4:0]      dump_idx,
    output logic [XLEN-1:0] dump_data,
    input  logic            dump_ready,
    output logic            halted,
    output logic [XLEN-1:0] halt_pc,
    output logic            good_trap,
    output logic [63:0]     instret,
    output logic [63:0]     cycles
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_DUMP   = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    localparam logic [4:0] DRAIN_LAST = 5'(DRAIN_MAX - 1);
    localparam logic [4:0] IDX_A0     = 5'd10;
    localparam logic [4:0] IDX_LAST   = 5'd31;

    logic [1:0]      state_q,     state_d;
    logic [4:0]      drain_cnt_q, drain_cnt_d;
    logic [4:0]      dump_idx_q,  dump_idx_d;
    logic [XLEN-1:0] halt_pc_q,   halt_pc_d;
    logic [XLEN-1:0] a0_q,        a0_d;
    logic            timeout_q,   timeout_d;
    logic [63:0]     instret_q,   instret_d;
    logic [63:0]     cycles_q,    cycles_d;

    logic            in_dump;
    logic [XLEN-1:0] beat_data;

    assign in_dump = (state_q == ST_DUMP);

    // x0 is architecturally zero regardless of what the register file returns.
    assign beat_data = (dump_idx_q == 5'd0) ? '0 : gpr_rdata;

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        dump_idx_d  = dump_idx_q;
        halt_pc_d   = halt_pc_q;
        a0_d        = a0_q;
        timeout_d   = timeout_q;
        instret_d   = instret_q;
        cycles_d    = (state_q == ST_HALTED) ? cycles_q : cycles_q + 64'd1;

        case (state_q)
            ST_RUN: begin
                if (commit_valid) begin
                    instret_d = instret_q + 64'd1;
                    if (commit_is_break) begin
                        state_d     = ST_DRAIN;
                        halt_pc_d   = commit_pc;
                        drain_cnt_d = 5'd0;
                    end
                end
            end
            ST_DRAIN: begin
                drain_cnt_d = drain_cnt_q + 5'd1;
                if (pipe_empty) begin
                    state_d    = ST_DUMP;
                    dump_idx_d = 5'd0;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    state_d    = ST_DUMP;
                    dump_idx_d = 5'd0;
                    timeout_d  = 1'b1;
                end
            end
            ST_DUMP: begin
                if (dump_ready) begin
                    if (dump_idx_q == IDX_A0) begin
                        a0_d = beat_data;
                    end
                    dump_idx_d = dump_idx_q + 5'd1;
                    if (dump_idx_q == IDX_LAST) begin
                        state_d = ST_HALTED;
                    end
                end
            end
            default: begin
                state_d = ST_HALTED;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= 5'd0;
            dump_idx_q  <= 5'd0;
            halt_pc_q   <= '0;
            a0_q        <= '0;
            timeout_q   <= 1'b0;
            instret_q   <= 64'd0;
            cycles_q    <= 64'd0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            dump_idx_q  <= dump_idx_d;
            halt_pc_q   <= halt_pc_d;
            a0_q        <= a0_d;
            timeout_q   <= timeout_d;
            instret_q   <= instret_d;
            cycles_q    <= cycles_d;
        end
    end

    assign stall_fetch = (state_q != ST_RUN);
    assign dump_valid  = in_dump;
    assign gpr_raddr   = in_dump ? dump_idx_q : 5'd0;
    assign dump_idx    = in_dump ? dump_idx_q : 5'd0;
    assign dump_data   = in_dump ? beat_data : '0;
    assign halted      = (state_q == ST_HALTED);
    assign good_trap   = halted && (a0_q == '0) && !timeout_q;
    assign halt_pc     = halt_pc_q;
    assign instret     = instret_q;
    assign cycles      = cycles_q;

endmodule

// File: tb/tb_commit_halt_ctrl.sv
// Directed bench for commit_halt_ctrl: halt, dump, backpressure, drain timeout and reset abort.
module tb_commit_halt_ctrl;

    localparam int XLEN = 64;

    logic            clk;
    logic            rst_n;
    logic            commit_valid;
    logic [XLEN-1:0] commit_pc;
    logic            commit_is_break;
    logic            pipe_empty;
    logic            stall_fetch;
    logic [4:0]      gpr_raddr;
    logic [XLEN-1:0] gpr_rdata;
    logic            dump_valid;
    logic [4:0]      dump_idx;
    logic [XLEN-1:0] dump_data;
    logic            dump_ready;
    logic            halted;
    logic [XLEN-1:0] halt_pc;
    logic            good_trap;
    logic [63:0]     instret;
    logic [63:0]     cycles;

    logic [XLEN-1:0] gpr [32];

    int vectors;
    int miscompares;

    commit_halt_ctrl #(.XLEN(XLEN), .DRAIN_MAX(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_is_break(commit_is_break), .pipe_empty(pipe_empty),
        .stall_fetch(stall_fetch), .gpr_raddr(gpr_raddr), .gpr_rdata(gpr_rdata),
        .dump_valid(dump_valid), .dump_idx(dump_idx), .dump_data(dump_data),
        .dump_ready(dump_ready), .halted(halted), .halt_pc(halt_pc),
        .good_trap(good_trap), .instret(instret), .cycles(cycles)
    );

    assign gpr_rdata = gpr[gpr_raddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        commit_valid    = 1'b0;
        commit_pc       = '0;
        commit_is_break = 1'b0;
        pipe_empty      = 1'b1;
        dump_ready      = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Retire one ebreak and return the number of negedges until dump_valid appears.
    task automatic break_and_wait(input logic [XLEN-1:0] pc, input logic empty, output int waited);
        commit_valid    = 1'b1;
        commit_pc       = pc;
        commit_is_break = 1'b1;
        pipe_empty      = empty;
        @(negedge clk);
        commit_valid    = 1'b0;
        commit_is_break = 1'b0;
        waited = 0;
        while (dump_valid !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        pipe_empty = 1'b1;
    endtask

    // Stream the dump with dump_ready asserted every 'period' cycles, checking every beat.
    task automatic run_dump(input string tag, input int period);
        int exp_idx = 0;
        int k = 0;
        logic [XLEN-1:0] exp_data;
        while (exp_idx < 32 && k < 200) begin
            exp_data = (exp_idx == 0) ? '0 : gpr[exp_idx];
            vectors++;
            if (dump_valid !== 1'b1 || dump_idx !== 5'(exp_idx) || gpr_raddr !== 5'(exp_idx)
                || dump_data !== exp_data || stall_fetch !== 1'b1) begin
                miscompares++;
                $display("FAIL %s beat k=%0d: valid=%b idx=%0d raddr=%0d data=%h, need valid=1 idx=%0d data=%h",
                         tag, k, dump_valid, dump_idx, gpr_raddr, dump_data, exp_idx, exp_data);
            end
            dump_ready = ((k % period) == 0);
            @(negedge clk);
            if (dump_ready) exp_idx++;
            k++;
        end
        dump_ready = 1'b0;
        vectors++;
        if (k !== 31 * period + 1 || halted !== 1'b1 || dump_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s dump length: cycles=%0d halted=%b valid=%b, need cycles=%0d halted=1 valid=0",
                     tag, k, halted, dump_valid, 31 * period + 1);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (stall_fetch !== 1'b0 || dump_valid !== 1'b0 || dump_idx !== 5'd0 || dump_data !== '0
            || halted !== 1'b0 || good_trap !== 1'b0 || gpr_raddr !== 5'd0) begin
            miscompares++;
            $display("FAIL reset outputs: stall=%b valid=%b idx=%0d data=%h halted=%b good=%b raddr=%0d, need all 0",
                     stall_fetch, dump_valid, dump_idx, dump_data, halted, good_trap, gpr_raddr);
        end
        vectors++;
        if (instret !== 64'd0 || cycles !== 64'd0 || halt_pc !== '0) begin
            miscompares++;
            $display("FAIL reset counters: instret=%0d cycles=%0d halt_pc=%h, need 0", instret, cycles, halt_pc);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_good_halt();
        int waited;
        apply_reset();
        gpr[10] = '0;
        for (int i = 0; i < 5; i++) begin
            commit_valid = 1'b1;
            commit_pc    = 64'h8000_0000 + 64'(4 * i);
            @(negedge clk);
            vectors++;
            if (stall_fetch !== 1'b0 || instret !== 64'(i + 1)) begin
                miscompares++;
                $display("FAIL run commit %0d: stall=%b instret=%0d, need stall=0 instret=%0d",
                         i, stall_fetch, instret, i + 1);
            end
        end
        // A second ebreak presented while draining must be ignored.
        commit_valid    = 1'b1;
        commit_pc       = 64'h8000_0014;
        commit_is_break = 1'b1;
        pipe_empty      = 1'b1;
        @(negedge clk);
        commit_pc = 64'h8000_0040;
        vectors++;
        if (stall_fetch !== 1'b1 || dump_valid !== 1'b0 || halt_pc !== 64'h8000_0014 || instret !== 64'd6) begin
            miscompares++;
            $display("FAIL drain entry: stall=%b valid=%b halt_pc=%h instret=%0d, need 1 0 80000014 6",
                     stall_fetch, dump_valid, halt_pc, instret);
        end
        @(negedge clk);
        commit_valid    = 1'b0;
        commit_is_break = 1'b0;
        waited = 0;
        while (dump_valid !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (waited !== 0 || halt_pc !== 64'h8000_0014 || instret !== 64'd6) begin
            miscompares++;
            $display("FAIL single drain cycle: extra wait=%0d halt_pc=%h instret=%0d, need 0 80000014 6",
                     waited, halt_pc, instret);
        end
        run_dump("good_halt", 1);
        vectors++;
        if (halted !== 1'b1 || good_trap !== 1'b1 || halt_pc !== 64'h8000_0014 || instret !== 64'd6
            || cycles !== 64'd39) begin
            miscompares++;
            $display("FAIL good halt status: halted=%b good=%b halt_pc=%h instret=%0d cycles=%0d, need 1 1 80000014 6 39",
                     halted, good_trap, halt_pc, instret, cycles);
        end
        commit_valid    = 1'b1;
        commit_is_break = 1'b1;
        commit_pc       = 64'h1234;
        repeat (3) @(negedge clk);
        idle_inputs();
        vectors++;
        if (halted !== 1'b1 || stall_fetch !== 1'b1 || instret !== 64'd6 || cycles !== 64'd39
            || halt_pc !== 64'h8000_0014 || dump_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL halted sticky: halted=%b stall=%b instret=%0d cycles=%0d halt_pc=%h valid=%b, need 1 1 6 39 80000014 0",
                     halted, stall_fetch, instret, cycles, halt_pc, dump_valid);
        end
    endtask

    task automatic test_bad_a0();
        int waited;
        apply_reset();
        gpr[10] = 64'd1;
        break_and_wait(64'h8000_0100, 1'b1, waited);
        run_dump("bad_a0", 1);
        vectors++;
        if (halted !== 1'b1 || good_trap !== 1'b0 || instret !== 64'd1) begin
            miscompares++;
            $display("FAIL bad a0 status: halted=%b good=%b instret=%0d, need 1 0 1", halted, good_trap, instret);
        end
        gpr[10] = '0;
    endtask

    task automatic test_backpressure();
        int waited;
        apply_reset();
        gpr[10] = '0;
        break_and_wait(64'h8000_0200, 1'b1, waited);
        run_dump("backpressure", 3);
        vectors++;
        if (good_trap !== 1'b1 || halt_pc !== 64'h8000_0200) begin
            miscompares++;
            $display("FAIL backpressure status: good=%b halt_pc=%h, need 1 80000200", good_trap, halt_pc);
        end
    endtask

    task automatic test_drain_timeout();
        int waited;
        apply_reset();
        gpr[10] = '0;
        break_and_wait(64'h8000_0300, 1'b0, waited);
        vectors++;
        if (waited !== 16) begin
            miscompares++;
            $display("FAIL drain timeout length: drain cycles=%0d, need 16", waited);
        end
        run_dump("timeout", 1);
        vectors++;
        if (halted !== 1'b1 || good_trap !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout status: halted=%b good=%b, need 1 0", halted, good_trap);
        end
    endtask

    task automatic test_reset_mid_dump();
        int waited;
        int k;
        apply_reset();
        gpr[10] = 64'd5;
        commit_valid = 1'b1;
        commit_pc    = 64'h8000_0400;
        @(negedge clk);
        break_and_wait(64'h8000_0404, 1'b1, waited);
        dump_ready = 1'b1;
        k = 0;
        while (dump_idx !== 5'd7 && k < 40) begin
            @(negedge clk);
            k++;
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (k !== 7 || halted !== 1'b0 || stall_fetch !== 1'b0 || dump_valid !== 1'b0 || dump_idx !== 5'd0
            || instret !== 64'd0 || cycles !== 64'd0 || halt_pc !== '0 || good_trap !== 1'b0) begin
            miscompares++;
            $display("FAIL reset abort: k=%0d halted=%b stall=%b valid=%b idx=%0d instret=%0d cycles=%0d halt_pc=%h, need k=7 and all 0",
                     k, halted, stall_fetch, dump_valid, dump_idx, instret, cycles, halt_pc);
        end
        idle_inputs();
        @(negedge clk);
        rst_n   = 1'b1;
        gpr[10] = '0;
        break_and_wait(64'h8000_0500, 1'b1, waited);
        run_dump("after_reset", 1);
        vectors++;
        if (halted !== 1'b1 || good_trap !== 1'b1 || instret !== 64'd1 || halt_pc !== 64'h8000_0500) begin
            miscompares++;
            $display("FAIL post-reset halt: halted=%b good=%b instret=%0d halt_pc=%h, need 1 1 1 80000500",
                     halted, good_trap, instret, halt_pc);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        for (int i = 0; i < 32; i++) begin
            gpr[i] = 64'hA5A5_0000_0000_0000 | (64'(i) << 16) | 64'(i * 7 + 1);
        end
        gpr[0] = 64'hDEAD;
        test_reset();
        test_good_halt();
        test_bad_a0();
        test_backpressure();
        test_drain_timeout();
        test_reset_mid_dump();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
